// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_pkg
// Description : Shared types and constants for the SRAM access sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

    localparam int SRAM_WAIT_MAX = 15;
    localparam int SRAM_ADDR_W   = 20;
    localparam int SRAM_DATA_W   = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_DONE  = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_HOLD  = 3'd5
    } sram_state_t;

endpackage
`default_nettype wire

// File: rtl/sram_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : sram_wait_counter
// Description : Wait-state down counter. Loads WAIT_CYCLES-1 on state entry,
//               decrements to zero and holds there; done flags zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_wait_counter
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic Clk,
    input  logic Reset_ah,
    input  logic load,
    output logic done
);

    localparam int              CNT_W      = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Load on entry, otherwise count down and stop at zero (no wrap).
    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= C_LOAD_VAL;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl
// Description : Converts CPU memory requests into timed active-low
//               asynchronous SRAM read/write cycles with programmable wait
//               states and a one-cycle ready pulse.
//               Optional macro SRAM_CTRL_STATS_EN adds saturating
//               rd_count / wr_count completion counters.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   Clk,
    input  logic                   Reset_ah,
    input  logic                   req,
    input  logic                   we,
    input  logic [15:0]            addr,
    input  logic [SRAM_DATA_W-1:0] wdata,
    output logic [SRAM_DATA_W-1:0] rdata,
    output logic                   ready,
    output logic                   busy,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    input  logic [SRAM_DATA_W-1:0] sram_din,
    output logic [SRAM_DATA_W-1:0] sram_dout,
    output logic                   sram_dq_oe,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic                   sram_ub_n,
`ifdef SRAM_CTRL_STATS_EN
    output logic                   sram_lb_n,
    output logic [15:0]            rd_count,
    output logic [15:0]            wr_count
`else
    output logic                   sram_lb_n
`endif
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > SRAM_WAIT_MAX) begin : g_bad_wait
        $error("sram_ctrl: WAIT_CYCLES out of range 1..15");
    end

    sram_state_t            r_state;
    sram_state_t            w_next;
    logic                   w_load;
    logic                   w_done;
    logic                   w_accept;
    logic [15:0]            r_addr;
    logic [SRAM_DATA_W-1:0] r_wdata;
    logic [SRAM_DATA_W-1:0] r_rdata;

    assign w_accept = (r_state == IDLE) && req;

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait (
        .Clk      (Clk),
        .Reset_ah (Reset_ah),
        .load     (w_load),
        .done     (w_done)
    );

    // State register; async reset drops every SRAM strobe immediately.
    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the wait counter is loaded on entry to a wait state.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (we) begin
                        w_next = WR_SETUP;
                    end else begin
                        w_next = RD_WAIT;
                        w_load = 1'b1;
                    end
                end
            end
            RD_WAIT:  if (w_done) w_next = RD_DONE;
            RD_DONE:  w_next = IDLE;
            WR_SETUP: begin
                w_next = WR_PULSE;
                w_load = 1'b1;
            end
            WR_PULSE: if (w_done) w_next = WR_HOLD;
            WR_HOLD:  w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // SRAM strobes decoded purely from state, so no input reaches an output.
    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        ready      = 1'b0;
        busy       = (r_state != IDLE);
        case (r_state)
            RD_WAIT: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
            end
            RD_DONE:  ready = 1'b1;
            WR_SETUP: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
            end
            WR_PULSE: begin
                sram_ce_n  = 1'b0;
                sram_we_n  = 1'b0;
                sram_dq_oe = 1'b1;
            end
            WR_HOLD: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                ready      = 1'b1;
            end
            default: ;
        endcase
        sram_ub_n = sram_ce_n;
        sram_lb_n = sram_ce_n;
    end

    // Request latch; the SRAM only ever sees these copies while busy.
    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

    // Read data captured on the edge leaving RD_WAIT; held across writes.
    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            r_rdata <= '0;
        end else if (r_state == RD_WAIT && w_done) begin
            r_rdata <= sram_din;
        end
    end

    assign sram_addr = {{(SRAM_ADDR_W - 16){1'b0}}, r_addr};
    assign sram_dout = r_wdata;
    assign rdata     = r_rdata;

`ifdef SRAM_CTRL_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    // Saturating completion counters, bumped on each ready pulse.
    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (r_state == RD_DONE && r_rd_count != 16'hFFFF) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (r_state == WR_HOLD && r_wr_count != 16'hFFFF) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_ctrl
// Description : Self-checking bench for sram_ctrl with a behavioural SRAM
//               and a scoreboard monitor on ready. Also exercises the
//               SRAM_CTRL_STATS_EN counters when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;

    localparam int W = 2;

    logic        Clk = 1'b0;
    logic        Reset_ah;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;
    logic        busy;
    logic [19:0] sram_addr;
    logic [15:0] sram_din;
    logic [15:0] sram_dout;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;
`ifdef SRAM_CTRL_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        is_wr;
        logic [15:0] a;
        logic [15:0] d;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] mem [0:255];

    sram_ctrl #(
        .WAIT_CYCLES (W)
    ) dut (
        .Clk        (Clk),
        .Reset_ah   (Reset_ah),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .busy       (busy),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
`ifdef SRAM_CTRL_STATS_EN
        .sram_lb_n  (sram_lb_n),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
`else
        .sram_lb_n  (sram_lb_n)
`endif
    );

    always #5 Clk = ~Clk;

    // Behavioural asynchronous SRAM: drives data while oe_n low, stores on we_n low.
    assign sram_din = sram_oe_n ? 16'h0000 : mem[sram_addr[7:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        if (busy) begin
            errors++;
            checks++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, n);
        end
    endtask

    task automatic do_read(input logic [15:0] a, input logic [15:0] d);
        wait_idle();
        exp_q.push_back('{1'b0, a, d});
        req  = 1'b1;
        we   = 1'b0;
        addr = a;
        tick();
        req = 1'b0;
        chk("rd_busy", {31'd0, busy}, 32'd1);
        chk("rd_sram_addr", {12'd0, sram_addr}, {16'd0, a});
        for (int n = 1; n <= W + 1; n++) begin
            if (n > 1) tick();
            chk("rd_oe_n", {31'd0, sram_oe_n}, (n <= W) ? 32'd0 : 32'd1);
            chk("rd_ready", {31'd0, ready}, (n == W + 1) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input bit toggle);
        wait_idle();
        exp_q.push_back('{1'b1, a, d});
        req   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        req = 1'b0;
        chk("wr_setup_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("wr_setup_dq_oe", {31'd0, sram_dq_oe}, 32'd1);
        chk("wr_setup_ce_n", {31'd0, sram_ce_n}, 32'd0);
        for (int n = 2; n <= W + 1; n++) begin
            tick();
            if (toggle) begin
                addr  = ~a;
                wdata = ~d;
            end
            chk("wr_pulse_we_n", {31'd0, sram_we_n}, 32'd0);
            chk("wr_pulse_addr", {12'd0, sram_addr}, {16'd0, a});
            chk("wr_pulse_dout", {16'd0, sram_dout}, {16'd0, d});
        end
        tick();
        chk("wr_hold_ready", {31'd0, ready}, 32'd1);
        chk("wr_hold_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("wr_hold_dq_oe", {31'd0, sram_dq_oe}, 32'd1);
    endtask

    // SRAM store and strobe-exclusion checks, sampled mid-cycle.
    always @(negedge Clk) begin
        if (!sram_we_n && !sram_ce_n && sram_dq_oe) mem[sram_addr[7:0]] = sram_dout;
        chk("we_oe_excl", {31'd0, (!sram_we_n && !sram_oe_n)}, 32'd0);
        chk("oe_dq_excl", {31'd0, (!sram_oe_n && sram_dq_oe)}, 32'd0);
    end

    // Scoreboard monitor: each ready pulse retires the oldest expected access.
    always @(negedge Clk) begin
        if (ready) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_ready: got ready=1 expected no pending access");
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_wr) chk("sb_wr_mem", {16'd0, mem[mon_e.a[7:0]]}, {16'd0, mon_e.d});
                else             chk("sb_rd_data", {16'd0, rdata}, {16'd0, mon_e.d});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h12] = 16'hBEEF;
        mem[8'h40] = 16'hA5A5;

        Reset_ah = 1'b1;
        req      = 1'b1;
        we       = 1'b0;
        addr     = 16'h0012;
        wdata    = 16'h0000;
        tick();
        tick();
        chk("rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_ub_lb_n", {30'd0, sram_ub_n, sram_lb_n}, 32'd3);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_sram_addr", {12'd0, sram_addr}, 32'd0);
        chk("rst_sram_dout", {16'd0, sram_dout}, 32'd0);
`ifdef SRAM_CTRL_STATS_EN
        chk("rst_counts", {rd_count, wr_count}, 32'd0);
`endif

        // Release with req still high: the read starts on the very next edge.
        Reset_ah = 1'b0;
        do_read(16'h0012, 16'hBEEF);
        do_write(16'h0030, 16'h1234, 1'b0);
        chk("rdata_hold_after_wr", {16'd0, rdata}, 32'h0000BEEF);
        do_read(16'h0030, 16'h1234);
        do_write(16'h0031, 16'hABCD, 1'b1);
        do_read(16'h0031, 16'hABCD);
        do_read(16'h0040, 16'hA5A5);
        wait_idle();
        chk("mem_30", {16'd0, mem[8'h30]}, 32'h00001234);
        chk("mem_31", {16'd0, mem[8'h31]}, 32'h0000ABCD);

        // Reset asserted part-way through the write pulse.
        req   = 1'b1;
        we    = 1'b1;
        addr  = 16'h0050;
        wdata = 16'h5555;
        tick();
        req = 1'b0;
        tick();
        chk("mid_we_n_before", {31'd0, sram_we_n}, 32'd0);
        #2 Reset_ah = 1'b1;
        #1;
        chk("mid_rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("mid_rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ce_n", {31'd0, sram_ce_n}, 32'd1);
        tick();
        Reset_ah = 1'b0;
        tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

`ifdef SRAM_CTRL_STATS_EN
        chk("stat_cleared", {rd_count, wr_count}, 32'd0);
        do_read(16'h0012, 16'hBEEF);
        do_read(16'h0030, 16'h1234);
        do_read(16'h0040, 16'hA5A5);
        do_write(16'h0060, 16'h0606, 1'b0);
        do_write(16'h0061, 16'h0616, 1'b0);
        tick();
        chk("stat_rd_count", {16'd0, rd_count}, 32'd3);
        chk("stat_wr_count", {16'd0, wr_count}, 32'd2);
        force dut.r_rd_count = 16'hFFFF;
        force dut.r_wr_count = 16'hFFFF;
        tick();
        release dut.r_rd_count;
        release dut.r_wr_count;
        do_read(16'h0012, 16'hBEEF);
        do_write(16'h0062, 16'h0626, 1'b0);
        tick();
        chk("stat_rd_sat", {16'd0, rd_count}, 32'h0000FFFF);
        chk("stat_wr_sat", {16'd0, wr_count}, 32'h0000FFFF);
        wait_idle();
        chk("queue_empty_stats", exp_q.size(), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
